// File: rtl/pc_tick_pkg.sv
// Shared types and helpers for the multi-cycle PC/tick sequencer.
package pc_tick_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } seq_state_e;

   localparam int DEF_TICKS   = 6;
   localparam int DEF_PC_STEP = 4;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pc_tick_seq_phase_counter.sv
// Modulo-TICKS phase counter with enable, clear and a wrap pulse on the final phase.
import pc_tick_pkg::*;

module phase_counter #(
   parameter int TICKS = DEF_TICKS,
   parameter int W     = clog2(TICKS)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clear_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(TICKS - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Wrap is combinational so the parent can act on the boundary in the same cycle.
   always_comb begin
      wrap_o  = en_i && (count_q == LAST);
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pc_tick_seq.sv
// Multi-cycle instruction sequencer: PC, phase tick, stall, branch redirect, halt/resume.
// Optional interrupt entry is enabled by defining PC_TICK_IRQ_EN.
import pc_tick_pkg::*;

module pc_tick_seq #(
   parameter int               PC_W     = 32,
   parameter int               TICKS    = DEF_TICKS,
   parameter int               PC_STEP  = DEF_PC_STEP,
   parameter logic [PC_W-1:0]  RESET_PC = '0,
`ifdef PC_TICK_IRQ_EN
   parameter logic [PC_W-1:0]  IRQ_VEC  = 'h80,
`endif
   localparam int              TICK_W   = clog2(TICKS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_valid,
   input  logic [PC_W-1:0]   br_target,
   input  logic              halt_req,
   input  logic              resume,
   output logic [PC_W-1:0]   pc,
   output logic [TICK_W-1:0] tick,
   output logic              fetch,
   output logic              last_tick,
   output logic              halted,
   output logic [31:0]       retired
`ifdef PC_TICK_IRQ_EN
   ,
   input  logic              irq,
   output logic              irq_ack,
   output logic [PC_W-1:0]   epc
`endif
);

   localparam logic [PC_W-1:0]   STEP_MASK = PC_W'(PC_STEP - 1);
   localparam logic [PC_W-1:0]   STEP_INC  = PC_W'(PC_STEP);
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS - 1);

   seq_state_e        state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       retired_q, retired_d;
   logic              pendBr_q, pendBr_d;
   logic [PC_W-1:0]   pendTgt_q, pendTgt_d;
   logic              pendHalt_q, pendHalt_d;
   logic [TICK_W-1:0] tickCount;
   logic              running;
   logic              advance;
   logic              boundary;
   logic [PC_W-1:0]   alignedTarget;
   logic [PC_W-1:0]   seqPc;
`ifdef PC_TICK_IRQ_EN
   logic              irqAck_q, irqAck_d;
   logic [PC_W-1:0]   epc_q, epc_d;
`endif

   assign running  = (state_q == RUN);
   assign advance  = running && !stall;

   phase_counter #(
      .TICKS (TICKS),
      .W     (TICK_W)
   ) u_phase (
      .clock   (clock),
      .reset   (reset),
      .en_i    (advance),
      .clear_i (!running),
      .count_o (tickCount),
      .wrap_o  (boundary)
   );

   // Targets are forced onto PC_STEP alignment; the address after this instruction
   // prefers a same-cycle redirect, then a captured one, then the sequential step.
   always_comb begin
      alignedTarget = br_target & ~STEP_MASK;
      if (br_valid) begin
         seqPc = alignedTarget;
      end else if (pendBr_q) begin
         seqPc = pendTgt_q;
      end else begin
         seqPc = pc_q + STEP_INC;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      retired_d  = retired_q;
      pendBr_d   = pendBr_q;
      pendTgt_d  = pendTgt_q;
      pendHalt_d = pendHalt_q;
`ifdef PC_TICK_IRQ_EN
      irqAck_d   = 1'b0;
      epc_d      = epc_q;
`endif
      case (state_q)
         RUN: begin
            if (boundary) begin
               retired_d = retired_q + 32'd1;
               pendBr_d  = 1'b0;
`ifdef PC_TICK_IRQ_EN
               if (irq) begin
                  // Interrupt wins over redirect; a halt request waits for the next boundary.
                  pc_d       = IRQ_VEC;
                  epc_d      = seqPc;
                  irqAck_d   = 1'b1;
                  pendHalt_d = pendHalt_q || halt_req;
               end else begin
                  pc_d       = seqPc;
                  pendHalt_d = 1'b0;
                  if (halt_req || pendHalt_q) begin
                     state_d = HALTED;
                  end
               end
`else
               pc_d       = seqPc;
               pendHalt_d = 1'b0;
               if (halt_req || pendHalt_q) begin
                  state_d = HALTED;
               end
`endif
            end else if (advance) begin
               if (br_valid) begin
                  pendBr_d  = 1'b1;
                  pendTgt_d = alignedTarget;
               end
               if (halt_req) begin
                  pendHalt_d = 1'b1;
               end
            end
         end
         HALTED: begin
            if (resume) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         retired_q  <= '0;
         pendBr_q   <= 1'b0;
         pendTgt_q  <= '0;
         pendHalt_q <= 1'b0;
`ifdef PC_TICK_IRQ_EN
         irqAck_q   <= 1'b0;
         epc_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         retired_q  <= retired_d;
         pendBr_q   <= pendBr_d;
         pendTgt_q  <= pendTgt_d;
         pendHalt_q <= pendHalt_d;
`ifdef PC_TICK_IRQ_EN
         irqAck_q   <= irqAck_d;
         epc_q      <= epc_d;
`endif
      end
   end

   assign pc        = pc_q;
   assign tick      = tickCount;
   assign fetch     = advance && (tickCount == '0);
   assign last_tick = advance && (tickCount == LAST_TICK);
   assign halted    = (state_q == HALTED);
   assign retired   = retired_q;
`ifdef PC_TICK_IRQ_EN
   assign irq_ack   = irqAck_q;
   assign epc       = epc_q;
`endif

endmodule

// File: tb/tb_pc_tick_seq.sv
// Directed bench for pc_tick_seq: default build plus a narrow TICKS=2/PC_W=8 instance.
// The interrupt scenario runs only when PC_TICK_IRQ_EN is defined.
module tb_pc_tick_seq;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        brValid;
   logic [31:0] brTarget;
   logic        haltReq;
   logic        resume;
   logic [31:0] pc;
   logic [2:0]  tick;
   logic        fetch;
   logic        lastTick;
   logic        halted;
   logic [31:0] retired;
`ifdef PC_TICK_IRQ_EN
   logic        irq;
   logic        irqAck;
   logic [31:0] epc;
   logic        irqAck2;
   logic [7:0]  epc2;
`endif

   logic [7:0]  pc2;
   logic [0:0]  tick2;
   logic        fetch2;
   logic        lastTick2;
   logic        halted2;
   logic [31:0] retired2;

   int testCount;
   int failCount;

   pc_tick_seq dut (
      .clock     (clock),
      .reset     (reset),
      .stall     (stall),
      .br_valid  (brValid),
      .br_target (brTarget),
      .halt_req  (haltReq),
      .resume    (resume),
      .pc        (pc),
      .tick      (tick),
      .fetch     (fetch),
      .last_tick (lastTick),
      .halted    (halted),
      .retired   (retired)
`ifdef PC_TICK_IRQ_EN
      ,
      .irq       (irq),
      .irq_ack   (irqAck),
      .epc       (epc)
`endif
   );

   pc_tick_seq #(
      .PC_W     (8),
      .TICKS    (2),
      .PC_STEP  (8),
      .RESET_PC (8'hF8)
   ) dutNarrow (
      .clock     (clock),
      .reset     (reset),
      .stall     (1'b0),
      .br_valid  (1'b0),
      .br_target (8'h00),
      .halt_req  (1'b0),
      .resume    (1'b0),
      .pc        (pc2),
      .tick      (tick2),
      .fetch     (fetch2),
      .last_tick (lastTick2),
      .halted    (halted2),
      .retired   (retired2)
`ifdef PC_TICK_IRQ_EN
      ,
      .irq       (1'b0),
      .irq_ack   (irqAck2),
      .epc       (epc2)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic st, input logic bv, input logic [31:0] bt,
                                input logic hr, input logic rs);
      stall    = st;
      brValid  = bv;
      brTarget = bt;
      haltReq  = hr;
      resume   = rs;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      reset     = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef PC_TICK_IRQ_EN
      irq = 1'b0;
`endif
      step(2);
      reset = 1'b0;

      // Reset values
      checkOutput("rst_pc", pc, 32'h0);
      checkOutput("rst_tick", {29'b0, tick}, 32'd0);
      checkOutput("rst_fetch", {31'b0, fetch}, 32'd1);
      checkOutput("rst_halted", {31'b0, halted}, 32'd0);
      checkOutput("rst_retired", retired, 32'd0);

      // Free run: tick cycles 0..5, pc advances by 4 each instruction
      for (int k = 0; k < 18; k++) begin
         checkOutput($sformatf("run_tick_%0d", k), {29'b0, tick}, 32'(k % 6));
         checkOutput($sformatf("run_pc_%0d", k), pc, 32'(4 * (k / 6)));
         checkOutput($sformatf("run_fetch_%0d", k), {31'b0, fetch}, 32'((k % 6) == 0));
         step(1);
      end
      checkOutput("run_retired", retired, 32'd3);
      checkOutput("run_pc_end", pc, 32'd12);

      // Stall for three cycles at tick 2
      step(2);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1);
         checkOutput("stall_tick", {29'b0, tick}, 32'd2);
         checkOutput("stall_pc", pc, 32'd12);
         checkOutput("stall_fetch", {31'b0, fetch}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(3);
      checkOutput("stall_lasttick", {31'b0, lastTick}, 32'd1);
      checkOutput("stall_pc_hold", pc, 32'd12);
      step(1);
      checkOutput("stall_pc_next", pc, 32'd16);
      checkOutput("stall_retired", retired, 32'd4);

      // Two mid-instruction redirects, the later one wins
      step(1);
      applyStimulus(1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("br_mid_pc_hold", pc, 32'd16);
      step(2);
      checkOutput("br_mid_pc", pc, 32'h200);
      checkOutput("br_mid_tick", {29'b0, tick}, 32'd0);

      // Redirect at the boundary with a misaligned target
      step(5);
      applyStimulus(1'b0, 1'b1, 32'h107, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("br_bnd_pc", pc, 32'h104);
      checkOutput("br_bnd_retired", retired, 32'd6);

      // Halt request mid-instruction, then ignored inputs, then resume
      step(2);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("halt_not_yet", {31'b0, halted}, 32'd0);
      step(3);
      checkOutput("halt_halted", {31'b0, halted}, 32'd1);
      checkOutput("halt_pc", pc, 32'h108);
      checkOutput("halt_tick", {29'b0, tick}, 32'd0);
      checkOutput("halt_fetch", {31'b0, fetch}, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0);
      step(2);
      checkOutput("halt_ign_pc", pc, 32'h108);
      checkOutput("halt_ign_halted", {31'b0, halted}, 32'd1);
      checkOutput("halt_ign_retired", retired, 32'd7);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("resume_fetch", {31'b0, fetch}, 32'd1);
      checkOutput("resume_halted", {31'b0, halted}, 32'd0);
      checkOutput("resume_pc", pc, 32'h108);
      step(6);
      checkOutput("resume_next_pc", pc, 32'h10C);

      // Reset in the middle of an instruction
      step(4);
      checkOutput("midrst_pre_tick", {29'b0, tick}, 32'd4);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checkOutput("midrst_pc", pc, 32'h0);
      checkOutput("midrst_tick", {29'b0, tick}, 32'd0);
      checkOutput("midrst_retired", retired, 32'd0);
      checkOutput("midrst_fetch", {31'b0, fetch}, 32'd1);

      // Narrow configuration: TICKS=2, PC_STEP=8, PC_W=8 wraps from F8 to 00
      checkOutput("narrow_pc0", {24'b0, pc2}, 32'hF8);
      step(1);
      checkOutput("narrow_tick1", {31'b0, tick2}, 32'd1);
      checkOutput("narrow_pc1", {24'b0, pc2}, 32'hF8);
      step(1);
      checkOutput("narrow_wrap_pc", {24'b0, pc2}, 32'h00);
      checkOutput("narrow_retired", retired2, 32'd1);

`ifdef PC_TICK_IRQ_EN
      // Interrupt at a boundary while a redirect is pending
      applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
      step(1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(2);
      irq = 1'b1;
      step(1);
      irq = 1'b0;
      checkOutput("irq_pc", pc, 32'h80);
      checkOutput("irq_epc", epc, 32'h40);
      checkOutput("irq_ack_hi", {31'b0, irqAck}, 32'd1);
      step(1);
      checkOutput("irq_ack_lo", {31'b0, irqAck}, 32'd0);
      checkOutput("irq_pc_hold", pc, 32'h80);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pc_tick_seq.md
Name: pc_tick_seq

Overview:
- Parametrised multi-cycle instruction sequencer. Holds the program counter and a per-instruction phase counter ("tick"); each instruction occupies TICKS cycles.
- Successor to the fixed 6-tick/+4 generator. Adds stall, branch redirect, halt/resume, boundary strobes and a retired-instruction counter.
- Drives fetch/decode/execute phase control in the teaching CPU core.

Parameters:
- PC_W, 32, program counter width.
- TICKS, 6, cycles per instruction; legal range 2..16.
- PC_STEP, 4, sequential PC increment; must be a power of two.
- RESET_PC, 0, PC value loaded on reset.
- TICK_W, derived localparam = clog2(TICKS); not overridable.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  freeze tick, pc and pending state this cycle
- br_valid  in  1  redirect request for the current instruction
- br_target  in  PC_W  redirect address
- halt_req  in  1  stop at the next instruction boundary
- resume  in  1  leave HALTED
- pc  out  PC_W  current instruction address
- tick  out  TICK_W  phase, 0..TICKS-1
- fetch  out  1  high when tick==0, state RUN and stall low
- last_tick  out  1  high when tick==TICKS-1, state RUN and stall low
- halted  out  1  state is HALTED
- retired  out  32  count of completed instructions

Behaviour:
- Reset values: pc=RESET_PC, tick=0, state=RUN, retired=0, pending branch and pending halt cleared.
  - fetch=1 in the first cycle after reset, unless stall is high.
  - Reset has priority over every other input.
- States and transitions:
  - RUN to HALTED only at a boundary with a halt pending.
  - HALTED to RUN on resume; tick stays 0 and pc is unchanged.
  - In HALTED: stall, br_valid and halt_req are ignored; tick and pc hold.
- RUN, stall high: all registers hold. br_valid and halt_req are not sampled that cycle.
- RUN, stall low, tick<TICKS-1: tick increments by 1.
- RUN, stall low, tick==TICKS-1 (boundary):
  - tick returns to 0 and retired increments by 1, wrapping modulo 2^32.
  - Next pc is chosen in this priority order:
    1. br_valid this cycle: br_target.
    2. Else a pending branch: the pending target.
    3. Else pc+PC_STEP, wrapping modulo 2^PC_W.
  - Pending branch and pending halt clear.
  - If halt_req is high this cycle or a halt is pending, next state is HALTED.
- Branch capture:
  - br_valid at a non-boundary tick latches br_target into the pending register.
  - If several requests arrive within one instruction, the last one wins.
- Target alignment: the low log2(PC_STEP) bits of any loaded target are forced to zero.
- Latency: a redirect takes effect on the first tick of the next instruction, never mid-instruction.

Optional Feature:
- Macro: PC_TICK_IRQ_EN.
- With the macro defined:
  - Adds parameter IRQ_VEC (default 'h80).
  - Adds ports irq (in, 1), irq_ack (out, 1) and epc (out, PC_W).
  - irq is level-sensitive and sampled at the boundary in RUN. It has priority over branch: pc=IRQ_VEC, epc=the pc that would otherwise have loaded, irq_ack pulses for 1 cycle, and the pending branch is discarded.
  - If halt is pending at the same boundary, the IRQ is taken first and the halt stays pending.
  - epc resets to 0.
- Without the macro: none of these ports or parameters exist, and behaviour is exactly as above.

Decomposition:
- Package pc_tick_pkg holds:
  - state enum {RUN, HALTED};
  - a clog2 helper function;
  - default constants DEF_TICKS=6 and DEF_PC_STEP=4.
- One sub-module, phase_counter: a modulo-TICKS counter with en/clear inputs, count output and wrap pulse. pc_tick_seq instantiates it for tick.

Test Plan (all with defaults unless noted):
- Free run: reset 2 cycles, then 18 cycles with no stall → pc goes 0, 4, 8, changing every 6 cycles; tick repeats 0..5; retired=3; fetch high exactly at tick 0.
- Stall: stall for 3 cycles at tick 2 → tick stays 2 and pc holds; the boundary is delayed by exactly 3 cycles.
- Branch captured mid-instruction: br_valid at tick 1 with 'h103, then br_valid at tick 3 with 'h200 → next pc='h200 (last wins, low bits already aligned); pc 'h103 is never taken.
- Branch at boundary and misalignment: br_valid with 'h107 at tick 5 → next pc='h104 in the following cycle.
- Halt and resume: halt_req at tick 2 → HALTED after tick 5 with pc=next address and halted=1. Asserting br_valid and stall there changes nothing. resume → tick 0 with fetch=1 in the next cycle.
- Configuration sweep: TICKS=2, PC_STEP=8, PC_W=8 starting at pc='hF8 → pc wraps to 'h00 after 2 cycles.
- Under PC_TICK_IRQ_EN: irq high at a boundary while a branch is pending → pc='h80, epc=branch target, irq_ack is a 1-cycle pulse.
- Reset mid-instruction at tick 4 → all outputs return to their reset values in the next cycle.
